// File: rtl/int_arith_pkg.sv
// -----------------------------------------------------------------------------
// int_arith_pkg
// Shared constants and helpers for the integer-field arithmetic pipelines
// (int_sub_pipe and the integer add pipeline).
//   DATA_W_DEF  - default total operand/result width
//   FRAC_W_DEF  - default number of low fraction bits
//   SUB_W_MAX   - widest integer field the helper function can handle
//   sub_int_field(d1, d2, sat, int_w) - integer-field subtract with borrow
//                                       and optional clamp-to-zero
// -----------------------------------------------------------------------------
package int_arith_pkg;

   localparam int DATA_W_DEF = 12;
   localparam int FRAC_W_DEF = 4;
   localparam int SUB_W_MAX  = 32;

   // Operands are integer fields already zero-extended to SUB_W_MAX bits.
   // Returns {borrow, diff}; diff is reduced modulo 2^int_w, or forced to
   // zero when sat is set and the subtraction borrowed.
   function automatic logic [SUB_W_MAX:0] sub_int_field(
      input logic [SUB_W_MAX-1:0] d1,
      input logic [SUB_W_MAX-1:0] d2,
      input logic                 sat,
      input int unsigned          int_w
   );
      logic [SUB_W_MAX:0]   full_s;
      logic [SUB_W_MAX-1:0] mask_s;
      logic [SUB_W_MAX-1:0] diff_s;
      logic                 borrow_s;
      full_s   = {1'b0, d1} - {1'b0, d2};
      // Both operands are zero-extended, so the top bit is the borrow of
      // the int_w-bit subtraction as well.
      borrow_s = full_s[SUB_W_MAX];
      mask_s   = ~({SUB_W_MAX{1'b1}} << int_w);
      if (sat && borrow_s) begin
         diff_s = {SUB_W_MAX{1'b0}};
      end else begin
         diff_s = full_s[SUB_W_MAX-1:0] & mask_s;
      end
      return {borrow_s, diff_s};
   endfunction

endpackage

// File: rtl/int_pipe_stage.sv
// -----------------------------------------------------------------------------
// int_pipe_stage
// One register stage of a stallable delay chain: valid bit plus data word.
// Loads when en_i is high, holds otherwise (bubbles are held too).
// Ports:
//   clk_i   - system clock
//   rst_i   - synchronous reset, active-high; clears valid and data
//   en_i    - advance enable for the whole pipe
//   valid_i - valid from the previous stage
//   data_i  - data word from the previous stage
//   valid_o - registered valid
//   data_o  - registered data word
// -----------------------------------------------------------------------------
module int_pipe_stage
   import int_arith_pkg::*;
#(
   parameter int WORD_W = DATA_W_DEF + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              valid_i,
   input  logic [WORD_W-1:0] data_i,
   output logic              valid_o,
   output logic [WORD_W-1:0] data_o
);

   logic              valid_r;
   logic [WORD_W-1:0] data_r;

   // Stage register: reset, shift on enable, hold on stall.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_r <= 1'b0;
         data_r  <= {WORD_W{1'b0}};
      end else if (en_i) begin
         valid_r <= valid_i;
         data_r  <= data_i;
      end else begin
         valid_r <= valid_r;
         data_r  <= data_r;
      end
   end

   assign valid_o = valid_r;
   assign data_o  = data_r;

endmodule

// File: rtl/int_sub_pipe.sv
// -----------------------------------------------------------------------------
// int_sub_pipe
// Pipelined fixed-point subtractor on the integer field with valid/ready
// handshake and full-pipeline stall. The fraction field of the result is
// always zero. Stage 1 computes, the remaining LATENCY-1 stages only delay.
// Ports:
//   clk_i       - system clock
//   rst_i       - synchronous reset, active-high
//   valid_i     - operand pair valid
//   ready_o     - operand pair can be accepted this cycle
//   data_1_i    - minuend
//   data_2_i    - subtrahend
//   sat_en_i    - clamp result to 0 on borrow (sampled with operands)
//   valid_o     - result valid
//   ready_i     - downstream accepts the result
//   data_diff_o - result, fraction bits always 0
//   borrow_o    - unsigned underflow on the integer field
//   occupancy_o - number of valid entries in the pipe
// -----------------------------------------------------------------------------
module int_sub_pipe
   import int_arith_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int FRAC_W  = FRAC_W_DEF,
   parameter int LATENCY = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_1_i,
   input  logic [DATA_W-1:0] data_2_i,
   input  logic              sat_en_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_diff_o,
   output logic              borrow_o,
   output logic [3:0]        occupancy_o
);

   localparam int INT_W  = DATA_W - FRAC_W;
   // Stored word: {borrow, diff_int, fraction zeros}.
   localparam int WORD_W = DATA_W + 1;

   logic                 adv_s;
   logic                 accept_s;
   logic                 consume_s;
   logic [SUB_W_MAX:0]   sub_res_s;
   logic [WORD_W-1:0]    stage1_word_s;
   logic                 s1_valid_r;
   logic [WORD_W-1:0]    s1_data_r;
   logic [LATENCY-1:0]   valid_chain_s;
   logic [WORD_W-1:0]    data_chain_s [LATENCY];
   logic [3:0]           occ_r;
   logic [SUB_W_MAX-1:INT_W]       sub_unused_s;
   logic [2*FRAC_W-1:0]            frac_unused_s;

   // The whole pipe shifts unless a valid result is blocked downstream.
   assign adv_s     = ~valid_o | ready_i;
   assign ready_o   = adv_s;
   assign accept_s  = valid_i & adv_s;
   assign consume_s = valid_o & ready_i;

   // Integer-field subtract for the operand pair at the input.
   always_comb begin
      sub_res_s     = sub_int_field(SUB_W_MAX'(data_1_i[DATA_W-1:FRAC_W]),
                                    SUB_W_MAX'(data_2_i[DATA_W-1:FRAC_W]),
                                    sat_en_i, INT_W);
      stage1_word_s = {sub_res_s[SUB_W_MAX], sub_res_s[INT_W-1:0],
                       {FRAC_W{1'b0}}};
   end

   // Bits that are intentionally ignored: fraction inputs and the upper
   // part of the helper's wide difference.
   assign sub_unused_s  = sub_res_s[SUB_W_MAX-1:INT_W];
   assign frac_unused_s = {data_1_i[FRAC_W-1:0], data_2_i[FRAC_W-1:0]};

   // Stage 1 register: captures the subtract result whenever the pipe moves.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_r <= 1'b0;
         s1_data_r  <= {WORD_W{1'b0}};
      end else if (adv_s) begin
         s1_valid_r <= valid_i;
         s1_data_r  <= stage1_word_s;
      end else begin
         s1_valid_r <= s1_valid_r;
         s1_data_r  <= s1_data_r;
      end
   end

   assign valid_chain_s[0] = s1_valid_r;
   assign data_chain_s[0]  = s1_data_r;

   // Pure delay stages 2..LATENCY share the same advance enable.
   for (genvar g = 1; g < LATENCY; g++) begin : g_delay
      int_pipe_stage #(
         .WORD_W (WORD_W)
      ) u_stage (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .en_i    (adv_s),
         .valid_i (valid_chain_s[g-1]),
         .data_i  (data_chain_s[g-1]),
         .valid_o (valid_chain_s[g]),
         .data_o  (data_chain_s[g])
      );
   end

   assign valid_o     = valid_chain_s[LATENCY-1];
   assign data_diff_o = data_chain_s[LATENCY-1][DATA_W-1:0];
   assign borrow_o    = data_chain_s[LATENCY-1][DATA_W];

   // Occupancy counter: tracks accepted-but-not-consumed entries.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         occ_r <= 4'd0;
      end else begin
         case ({accept_s, consume_s})
            2'b10:   occ_r <= occ_r + 4'd1;
            2'b01:   occ_r <= occ_r - 4'd1;
            default: occ_r <= occ_r;
         endcase
      end
   end

   assign occupancy_o = occ_r;

endmodule

// File: tb/tb_int_sub_pipe.sv
// -----------------------------------------------------------------------------
// tb_int_sub_pipe
// Directed/random bench for int_sub_pipe (default parameters: 12-bit data,
// 4 fraction bits, latency 5). Expected results are queued on acceptance
// and compared when the DUT hands a result over.
// -----------------------------------------------------------------------------
module tb_int_sub_pipe;

   typedef struct {
      logic [12:0] exp;
      int          acc_cyc;
   } sb_entry_t;

   logic        clk_i;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [11:0] data_1_i;
   logic [11:0] data_2_i;
   logic        sat_en_i;
   logic        valid_o;
   logic        ready_i;
   logic [11:0] data_diff_o;
   logic        borrow_o;
   logic [3:0]  occupancy_o;

   int          total;
   int          bad;
   int          cyc;
   int          occ_exp;
   bit          lat_chk;
   sb_entry_t   sb [$];

   int_sub_pipe dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .data_1_i    (data_1_i),
      .data_2_i    (data_2_i),
      .sat_en_i    (sat_en_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .data_diff_o (data_diff_o),
      .borrow_o    (borrow_o),
      .occupancy_o (occupancy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Reference: {borrow, result word} for one operand pair.
   function automatic logic [12:0] model(input logic [11:0] a,
                                         input logic [11:0] b,
                                         input logic s);
      int         ia;
      int         ib;
      logic [7:0] d;
      logic       br;
      ia = int'(a[11:4]);
      ib = int'(b[11:4]);
      if (ia >= ib) begin
         br = 1'b0;
         d  = 8'(ia - ib);
      end else begin
         br = 1'b1;
         d  = s ? 8'd0 : 8'(ia + 256 - ib);
      end
      return {br, d, 4'b0000};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)",
                tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, then check the
   // settled outputs and update the scoreboard and occupancy model.
   task automatic step(input logic v, input logic [11:0] a,
                       input logic [11:0] b, input logic s,
                       input logic rdy, input logic rst);
      sb_entry_t e;
      bit        acc;
      bit        con;
      @(negedge clk_i);
      rst_i    = rst;
      valid_i  = v;
      data_1_i = a;
      data_2_i = b;
      sat_en_i = s;
      ready_i  = rdy;
      #1;
      if (!rst) begin
         chk("occupancy", 32'(occupancy_o), 32'(occ_exp));
         if (rdy) chk("ready_o_open", 32'(ready_o), 32'd1);
         con = (valid_o === 1'b1) && rdy;
         if (con) begin
            if (sb.size() == 0) begin
               chk("spurious_valid", 32'(valid_o), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("data_diff", 32'(data_diff_o), 32'(e.exp[11:0]));
               chk("borrow", 32'(borrow_o), 32'(e.exp[12]));
               chk("frac_zero", 32'(data_diff_o[3:0]), 32'd0);
               if (lat_chk) chk("latency", 32'(cyc - e.acc_cyc), 32'd5);
            end
         end
         acc = v && (ready_o === 1'b1);
         if (acc) begin
            e.exp     = model(a, b, s);
            e.acc_cyc = cyc;
            sb.push_back(e);
         end
         occ_exp = occ_exp + (acc ? 1 : 0) - (con ? 1 : 0);
      end else begin
         sb.delete();
         occ_exp = 0;
      end
      cyc++;
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 12'h000, 12'h000, 1'b0, rdy, 1'b0);
   endtask

   // Run idle cycles until every queued result has come out (bounded).
   task automatic drain();
      for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1'b1);
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      logic [11:0] ra;
      logic [11:0] rb;
      logic        rs;
      total    = 0;
      bad      = 0;
      cyc      = 0;
      occ_exp  = 0;
      lat_chk  = 1'b1;
      rst_i    = 1'b1;
      valid_i  = 1'b0;
      data_1_i = 12'h000;
      data_2_i = 12'h000;
      sat_en_i = 1'b0;
      ready_i  = 1'b1;

      // Reset and reset-state checks.
      step(1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b1);
      step(1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b1);
      idle(1'b1);
      chk("rst_valid_o", 32'(valid_o), 32'd0);
      chk("rst_data_diff", 32'(data_diff_o), 32'h000);
      chk("rst_borrow", 32'(borrow_o), 32'd0);
      chk("rst_occupancy", 32'(occupancy_o), 32'd0);
      chk("rst_ready_o", 32'(ready_o), 32'd1);

      // Basic subtract, wrap, clamp, equal operands.
      step(1'b1, 12'h150, 12'h0A3, 1'b0, 1'b1, 1'b0);
      drain();
      step(1'b1, 12'h0A3, 12'h150, 1'b0, 1'b1, 1'b0);
      step(1'b1, 12'h0A3, 12'h150, 1'b1, 1'b1, 1'b0);
      step(1'b1, 12'h7C9, 12'h7C2, 1'b1, 1'b1, 1'b0);
      step(1'b1, 12'hFFF, 12'h00F, 1'b0, 1'b1, 1'b0);
      drain();

      // Back-to-back streaming of 20 random pairs.
      for (int i = 0; i < 20; i++) begin
         ra = 12'($urandom_range(0, 4095));
         rb = 12'($urandom_range(0, 4095));
         rs = 1'($urandom_range(0, 1));
         step(1'b1, ra, rb, rs, 1'b1, 1'b0);
      end
      drain();

      // Backpressure: fill with 5, stall 7 cycles, then release.
      lat_chk = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ra = 12'($urandom_range(0, 4095));
         rb = 12'($urandom_range(0, 4095));
         step(1'b1, ra, rb, 1'b0, 1'b1, 1'b0);
      end
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 12'h5A5, 12'h111, 1'b0, 1'b0, 1'b0);
         chk("stall_ready_o", 32'(ready_o), 32'd0);
         chk("stall_valid_o", 32'(valid_o), 32'd1);
         chk("stall_occupancy", 32'(occupancy_o), 32'd5);
         if (sb.size() > 0) begin
            chk("stall_data_hold", 32'(data_diff_o), 32'(sb[0].exp[11:0]));
            chk("stall_borrow_hold", 32'(borrow_o), 32'(sb[0].exp[12]));
         end else begin
            chk("stall_sb_size", 32'(sb.size()), 32'd5);
         end
      end
      drain();
      lat_chk = 1'b1;

      // Mid-stream reset discards in-flight data.
      step(1'b1, 12'h300, 12'h100, 1'b0, 1'b1, 1'b0);
      step(1'b1, 12'h400, 12'h100, 1'b0, 1'b1, 1'b0);
      step(1'b1, 12'h500, 12'h100, 1'b0, 1'b1, 1'b0);
      step(1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b1);
      idle(1'b1);
      chk("mrst_valid_o", 32'(valid_o), 32'd0);
      chk("mrst_occupancy", 32'(occupancy_o), 32'd0);
      chk("mrst_data_diff", 32'(data_diff_o), 32'h000);
      for (int i = 0; i < 10; i++) begin
         idle(1'b1);
         chk("mrst_no_stale", 32'(valid_o), 32'd0);
      end

      // Bubbles: inputs on relative cycles 0, 2, 3.
      step(1'b1, 12'h820, 12'h310, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      step(1'b1, 12'h120, 12'h340, 1'b0, 1'b1, 1'b0);
      step(1'b1, 12'h120, 12'h340, 1'b1, 1'b1, 1'b0);
      drain();
      for (int i = 0; i < 3; i++) idle(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/int_sub_pipe.md
Name: int_sub_pipe

Overview:
Pipelined fixed-point subtractor, the inverse partner of the integer add pipeline in the float_arith/int datapath. It computes data_1_i − data_2_i on the integer field only; the fraction field is forced to zero. Unlike the free-running adder, it carries a valid/ready handshake with full-pipeline stall, a borrow flag and optional clamp-to-zero, so it can sit directly between streaming neural-processor stages.

Parameters:
DATA_W, 12, total operand/result width
FRAC_W, 4, low fraction bits; forced to 0 on output, excluded from the subtraction
LATENCY, 5, cycles from an accepted input to valid_o with no stall; legal range 2..8

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
valid_i  in  1  operand pair valid
ready_o  out  1  block can accept an operand pair this cycle
data_1_i  in  DATA_W  minuend
data_2_i  in  DATA_W  subtrahend
sat_en_i  in  1  1 = clamp to 0 on borrow; sampled with the operands
valid_o  out  1  result valid
ready_i  in  1  downstream accepts the result
data_diff_o  out  DATA_W  result; bits [FRAC_W-1:0] always 0
borrow_o  out  1  1 = unsigned underflow on the integer field
occupancy_o  out  4  number of valid entries in the pipe (0..LATENCY)

Behaviour:
- Single clock domain. rst_i is synchronous and active-high.
- Reset: all stage valids = 0, all stage data = 0. valid_o = 0, data_diff_o = 0, borrow_o = 0, occupancy_o = 0, ready_o = 1 in the first cycle after reset.
- Input handshake: an input is accepted when valid_i & ready_o.
- Output handshake: a result is consumed when valid_o & ready_i.
- Stall: adv = ~valid_o | ready_i. ready_o = adv. This is a combinational path from ready_i to ready_o, which is accepted.
- When adv = 1, every stage shifts one place. When adv = 0, every stage holds, including bubbles (no bubble collapse).
- Stage 1 (on acceptance):
  - {borrow, diff_int} = {1'b0, d1[DATA_W-1:FRAC_W]} − {1'b0, d2[DATA_W-1:FRAC_W]}, computed (DATA_W−FRAC_W+1) bits wide.
  - If sat_en & borrow: diff_int = 0. Otherwise diff_int wraps modulo 2^(DATA_W−FRAC_W).
  - The stored word is {diff_int, FRAC_W'b0} plus the borrow bit.
- Stages 2..LATENCY are pure delay (data, borrow, valid). The last stage drives the outputs directly from registers.
- Latency: exactly LATENCY cycles from acceptance to valid_o when ready_i is held at 1. Throughput is 1 per cycle.
- While valid_o = 1 and ready_i = 0:
  - data_diff_o and borrow_o hold stable.
  - ready_o = 0 and no input is accepted.
- Input bubbles (adv = 1, valid_i = 0) enter as invalid stages. data_diff_o/borrow_o may change under valid_o = 0, and the bench must not check them then.
- occupancy_o is a registered counter:
  - +1 on accept without consume.
  - −1 on consume without accept.
  - Unchanged when both or neither happen.
  - Must equal the popcount of the stage valid bits at all times and never exceed LATENCY.
- Reset asserted mid-stream: all in-flight data is discarded and state returns to reset values on the next edge. No output appears for inputs accepted before reset.
- Equal operands: result 0, borrow 0.

Decomposition:
- Shared package int_arith_pkg holds DATA_W_DEF = 12, FRAC_W_DEF = 4 and the function sub_int_field(d1, d2, sat) returning {borrow, diff}. The integer adder will also switch to these constants.
- One sub-module, int_pipe_stage: a single register stage with valid, enable and synchronous reset, generated LATENCY−1 times for the delay chain.
- Stage 1 and the occupancy counter live in int_sub_pipe.

Test Plan:
- Basic subtract: reset, ready_i = 1, drive 0x150 − 0x0A3, sat 0 → exactly 5 cycles later valid_o = 1, data_diff_o = 0x0B0, borrow_o = 0.
- Wrap and clamp: 0x0A3 − 0x150 with sat 0 → 0xF50, borrow 1. Same operands with sat 1 → 0x000, borrow 1.
- Back-to-back streaming: 20 random pairs on consecutive cycles, ready_i = 1 → 20 results in order, one per cycle starting at cycle 5, matching the reference model, with fraction bits 0.
- Backpressure: fill with 5 inputs, then ready_i = 0 for 7 cycles → ready_o = 0, data_diff_o stable, occupancy_o = 5. Release → all 5 results drain in order, none lost or duplicated.
- Mid-stream reset: 3 inputs accepted, rst_i pulsed 1 cycle → next cycle valid_o = 0, occupancy_o = 0, data_diff_o = 0x000, and no stale result appears in the following 10 cycles.
- Bubbles: inputs on cycles 0, 2, 3 → valid_o high on cycles 5, 7, 8 only, with occupancy_o tracking 1, 1, 2, 3, ... per the counter rule.
